gate_truth_checker: RTL and testbench



---
 rtl/gate_check_pkg.sv | 24 ++
 rtl/gate_settle_timer.sv | 30 +++
 rtl/gate_truth_checker.sv | 138 +++++++++++++
 tb/tb_gate_truth_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
package gate_check_pkg;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } gc_state_e;

    // Truth tables for two-input gates, bit v = output for input vector v (a = bit 1, b = bit 0)
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    // Width of a counter that must hold values 0..settle-1 (never narrower than one bit)
    function automatic int settle_cnt_w(input int settle);
        return (settle > 2) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter with a zero flag; times how long each vector is held before sampling.
module gate_settle_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Load wins over decrement; decrement stops at zero so the flag stays asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector into a small combinational gate, waits a settle time, samples its
// output and compares it against an expected truth table; reports pass, error count and fail mask.
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int                N_IN   = 2,
    parameter int                SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXPECT = TT_NAND
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N_IN-1:0]     dut_in,
    input  logic                dut_c,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       err_count,
    output logic [2**N_IN-1:0]  fail_mask
);

    localparam int                 NV        = 2**N_IN;
    localparam int                 CNT_W     = settle_cnt_w(SETTLE);
    localparam logic [N_IN-1:0]    VEC_MAX   = '1;
    localparam logic [N_IN-1:0]    VEC_ONE   = N_IN'(1);
    localparam logic [N_IN:0]      ERR_ONE   = (N_IN+1)'(1);
    localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE - 1);

    // A zero settle time would sample the gate in the same cycle the vector changes
    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("gate_truth_checker: SETTLE must be at least 1");
        end
    endgenerate

    gc_state_e         state, state_nx;
    logic [N_IN-1:0]   vec, vec_nx;
    logic [N_IN:0]     err_nx;
    logic [NV-1:0]     mask_nx;
    logic              pass_nx;
    logic              mismatch;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;

    gate_settle_timer #(
        .CNT_W(CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SETTLE_LD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, sweep bookkeeping and timer control
    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        err_nx   = err_count;
        mask_nx  = fail_mask;
        pass_nx  = pass;
        mismatch = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WAIT;
                    vec_nx   = '0;
                    err_nx   = '0;
                    mask_nx  = '0;
                    pass_nx  = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            WAIT: begin
                if (tmr_zero) begin
                    state_nx = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CHECK: begin
                // Case inequality so an undriven or X gate output is reported as a mismatch
                mismatch = (dut_c !== EXPECT[vec]);
                if (mismatch) begin
                    err_nx       = err_count + ERR_ONE;
                    mask_nx[vec] = 1'b1;
                end
                if (vec == VEC_MAX) begin
                    state_nx = DONE;
                    pass_nx  = (err_nx == '0);
                end else begin
                    vec_nx   = vec + VEC_ONE;
                    tmr_load = 1'b1;
                    state_nx = WAIT;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Result and vector registers; vector is held after the sweep so the gate sees no glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= '0;
            err_count <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else begin
            vec       <= vec_nx;
            err_count <= err_nx;
            fail_mask <= mask_nx;
            pass      <= pass_nx;
        end
    end

    assign dut_in = vec;
    assign busy   = (state == WAIT) || (state == CHECK);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker with a cycle-level reference model of the default instance.
`timescale 1ns/1ps
module tb_gate_truth_checker;
    import gate_check_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    bit   stuck = 1'b0;

    logic [1:0] dut_in_a, dut_in_b, dut_in_c, dut_in_d;
    logic       dut_c_a, dut_c_b, dut_c_c, dut_c_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       done_a, done_b, done_c, done_d;
    logic       pass_a, pass_b, pass_c, pass_d;
    logic [2:0] err_a, err_b, err_c, err_d;
    logic [3:0] mask_a, mask_b, mask_c, mask_d;
    bit   [2:0] dly_c, dly_d;

    int n_checks = 0;
    int n_fail   = 0;

    // Gates under test
    assign dut_c_a = stuck ? 1'b0 : ~&dut_in_a;
    assign dut_c_b = ~&dut_in_b;
    assign dut_c_c = dly_c[2];
    assign dut_c_d = dly_d[2];
    always @(posedge clk) begin
        dly_c <= {dly_c[1:0], ~&dut_in_c};
        dly_d <= {dly_d[1:0], ~&dut_in_d};
    end

    gate_truth_checker u_a (
        .clk(clk), .rst(rst), .start(start), .dut_in(dut_in_a), .dut_c(dut_c_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_mask(mask_a));

    gate_truth_checker #(.EXPECT(TT_AND)) u_b (
        .clk(clk), .rst(rst), .start(start), .dut_in(dut_in_b), .dut_c(dut_c_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_mask(mask_b));

    gate_truth_checker #(.SETTLE(4)) u_c (
        .clk(clk), .rst(rst), .start(start2), .dut_in(dut_in_c), .dut_c(dut_c_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .fail_mask(mask_c));

    gate_truth_checker #(.SETTLE(1)) u_d (
        .clk(clk), .rst(rst), .start(start2), .dut_in(dut_in_d), .dut_c(dut_c_d),
        .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d), .fail_mask(mask_d));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep accepted at edge k occupies cycles k+1..k+13 (3 per vector, done at 13)
    int edge_n = 0;
    int k      = 0;
    bit active = 1'b0;
    bit m_init = 1'b0;
    bit m_stuck = 1'b0;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) begin
            active <= 1'b0;
            m_init <= 1'b1;
        end else if (start && (!active || (edge_n + 1 > k + 13))) begin
            k       <= edge_n + 1;
            active  <= 1'b1;
            m_stuck <= stuck;
        end
    end

    function automatic bit gate_resp(input int v, input bit stk);
        return stk ? 1'b0 : (v != 3);
    endfunction

    // Compare the default instance against the model on every cycle after the first reset
    always @(negedge clk) begin
        int q;
        int e_in, e_err;
        bit e_busy, e_done, e_pass;
        bit [3:0] e_mask;
        bit [3:0] tt;
        tt = TT_NAND;
        e_in = 0; e_err = 0; e_busy = 0; e_done = 0; e_pass = 0; e_mask = '0;
        if (m_init) begin
            if (active) begin
                q = edge_n - k + 1;
                e_busy = (q >= 1) && (q <= 12);
                e_done = (q == 13);
                e_in   = (q <= 12) ? (q - 1) / 3 : 3;
                for (int v = 0; v < 4; v++) begin
                    if ((3 * v + 3 <= q - 1) && (gate_resp(v, m_stuck) != tt[v])) begin
                        e_err++;
                        e_mask[v] = 1'b1;
                    end
                end
                e_pass = (q >= 13) && (e_err == 0);
            end
            chk("busy", busy_a, e_busy);
            chk("done", done_a, e_done);
            chk("dut_in", dut_in_a, e_in);
            chk("err_count", err_a, e_err);
            chk("fail_mask", mask_a, e_mask);
            chk("pass", pass_a, e_pass);
        end
    end

    int done_cnt_a = 0;
    always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done_a(input string name, input int bound, output int done_edge);
        done_edge = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                done_edge = edge_n;
                break;
            end
        end
        if (done_edge < 0) chk({name, "_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s, de, de2, dc0;
        bit seen_c, seen_d;
        bit pc, pd;
        int ec, ed;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);

        // Scenario 1: NAND gate, NAND table
        start = 1'b1; s = edge_n + 1; tick(1); start = 1'b0;
        wait_done_a("s1", 40, de);
        chk("s1_done_latency", de + 1 - s, 13);
        chk("s1_pass", pass_a, 1);
        chk("s1_err", err_a, 0);
        chk("s1_mask", mask_a, 4'b0000);
        // Scenario 2: same sweep on the instance expecting AND
        chk("s2_pass", pass_b, 0);
        chk("s2_err", err_b, 4);
        chk("s2_mask", mask_b, 4'b1111);

        // Scenario 3: output stuck at 0
        tick(2);
        stuck = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        wait_done_a("s3", 40, de);
        chk("s3_err", err_a, 3);
        chk("s3_mask", mask_a, 4'b0111);
        chk("s3_pass", pass_a, 0);
        stuck = 1'b0;

        // Scenario 4: reset mid-sweep
        tick(2);
        start = 1'b1; tick(1); start = 1'b0;
        tick(4);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("s4_busy", busy_a, 0);
        chk("s4_dut_in", dut_in_a, 0);
        chk("s4_err", err_a, 0);
        chk("s4_mask", mask_a, 0);
        dc0 = done_cnt_a;
        tick(20);
        chk("s4_no_done", done_cnt_a - dc0, 0);
        start = 1'b1; s = edge_n + 1; tick(1); start = 1'b0;
        wait_done_a("s4b", 40, de);
        chk("s4b_latency", de + 1 - s, 13);
        chk("s4b_pass", pass_a, 1);
        chk("s4b_err", err_a, 0);

        // Scenario 5: start held through the sweep and into the cycle after DONE
        tick(2);
        dc0 = done_cnt_a;
        start = 1'b1; s = edge_n + 1;
        wait_done_a("s5", 40, de);
        chk("s5_latency", de + 1 - s, 13);
        chk("s5_one_done", done_cnt_a - dc0, 1);
        tick(1); start = 1'b0;
        wait_done_a("s5b", 40, de2);
        chk("s5b_latency", de2 + 1 - (s + 14), 13);
        chk("s5b_two_done", done_cnt_a - dc0, 2);

        // Scenario 5c: extra start pulses while waiting
        tick(2);
        dc0 = done_cnt_a;
        start = 1'b1; s = edge_n + 1; tick(1); start = 1'b0;
        tick(1); start = 1'b1; tick(1); start = 1'b0;
        tick(3); start = 1'b1; tick(1); start = 1'b0;
        wait_done_a("s5c", 40, de);
        chk("s5c_latency", de + 1 - s, 13);
        chk("s5c_one_done", done_cnt_a - dc0, 1);
        tick(3);
        chk("s5c_idle_after", busy_a, 0);

        // Scenario 6: delayed NAND with long and short settle times
        seen_c = 0; seen_d = 0; pc = 0; pd = 0; ec = 0; ed = 0;
        start2 = 1'b1; tick(1); start2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_c === 1'b1 && !seen_c) begin seen_c = 1; pc = pass_c; ec = err_c; end
            if (done_d === 1'b1 && !seen_d) begin seen_d = 1; pd = pass_d; ed = err_d; end
            if (seen_c && seen_d) break;
        end
        chk("s6_c_done_seen", seen_c, 1);
        chk("s6_d_done_seen", seen_d, 1);
        chk("s6_c_pass", pc, 1);
        chk("s6_c_err", ec, 0);
        chk("s6_d_pass", pd, 0);
        chk("s6_d_err_nonzero", (ed != 0), 1);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
